// File: rtl/pearl_pkg.sv
// Shared types for the unified memory-port arbiter.
//   WORD_W        : bus word width
//   access_size_e : load/store access size
//   arb_state_e   : arbiter FSM states
//   owner_e       : current owner of the memory port
package pearl_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } access_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        IF   = 2'd1,
        D    = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-bus handshakes around the arbiter.
//   master : arbiter view (takes pipeline requests, drives the bus)
//   slave  : environment view (pipeline requesters and memory)
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    // IF-stage fetch port
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;

    // MEM-stage load/store port
    logic              d_we_i;
    logic              d_re_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [STRB_W-1:0] d_strb_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic [1:0]        d_byte_lane_i;
    logic [1:0]        d_size_i;
    logic              d_unsigned_i;
    logic              d_done_o;
    logic [DATA_W-1:0] d_rdata_o;
    logic              d_stall_o;

    // Memory bus
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [STRB_W-1:0] mem_strb_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport master (
        input  if_req_i, if_addr_i,
        input  d_we_i, d_re_i, d_addr_i, d_strb_i, d_wdata_i,
        input  d_byte_lane_i, d_size_i, d_unsigned_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output if_rvalid_o, if_rdata_o,
        output d_done_o, d_rdata_o, d_stall_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_strb_o, mem_wdata_o
    );

    modport slave (
        output if_req_i, if_addr_i,
        output d_we_i, d_re_i, d_addr_i, d_strb_i, d_wdata_i,
        output d_byte_lane_i, d_size_i, d_unsigned_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  if_rvalid_o, if_rdata_o,
        input  d_done_o, d_rdata_o, d_stall_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_strb_o, mem_wdata_o
    );

endinterface

// File: rtl/mem_port_arbiter_load_align.sv
// load_align: combinational lane extraction and sign/zero extension of a load.
//   i_rdata    : raw bus word
//   i_lane     : byte lane of the access
//   i_size     : 00 byte, 01 half, 10/11 word
//   i_unsigned : zero-extend instead of sign-extend
//   o_data     : aligned, extended result
module load_align
    import pearl_pkg::*;
(
    input  logic [WORD_W-1:0] i_rdata,
    input  logic [1:0]        i_lane,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    output logic [WORD_W-1:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'(i_rdata >> {i_lane, 3'b000});
        // Halfword selection only looks at the upper lane bit.
        w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_size)
            BYTE:    o_data = {{(WORD_W - 8){w_byte[7] & ~i_unsigned}}, w_byte};
            HALF:    o_data = {{(WORD_W - 16){w_half[15] & ~i_unsigned}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and the
// MEM-stage load/store path, one transaction at a time (IDLE -> REQ -> RESP).
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus           : fetch, data and memory-bus handshakes (master modport)
// Optional: PEARL_ARB_RR_EN selects round-robin arbitration; otherwise data
// accesses have fixed priority over fetches.
module mem_port_arbiter
    import pearl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    mem_port_arbiter_if.master bus
);
    localparam int unsigned STRB_W = DATA_W / 8;

    arb_state_e        r_state, w_state_nxt;
    owner_e            r_owner, w_owner_nxt, w_sel;
    logic              w_d_req, w_latch, w_in_req, w_resp, w_if_hit, w_d_hit;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [STRB_W-1:0] r_strb;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_lane;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [DATA_W-1:0] w_load;

    assign w_d_req = bus.d_we_i | bus.d_re_i;
    assign w_in_req = (r_state == REQ);
    assign w_resp   = (r_state == RESP) & bus.mem_rvalid_i;

    // Owner selection for a new transaction in IDLE.
`ifdef PEARL_ARB_RR_EN
    owner_e r_last;

    always_comb begin
        w_sel = NONE;
        if (w_d_req && bus.if_req_i) w_sel = (r_last == D) ? IF : D;
        else if (w_d_req)            w_sel = D;
        else if (bus.if_req_i)       w_sel = IF;
    end

    // Remember who completed last so a tie goes to the other requester.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     r_last <= IF;
        else if (w_resp) r_last <= r_owner;
    end
`else
    always_comb begin
        w_sel = NONE;
        if (w_d_req)           w_sel = D;
        else if (bus.if_req_i) w_sel = IF;
    end
`endif

    // FSM next state and owner.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_latch     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sel != NONE) begin
                    w_state_nxt = REQ;
                    w_owner_nxt = w_sel;
                    w_latch     = 1'b1;
                end
            end
            REQ: begin
                if (bus.mem_gnt_i) w_state_nxt = RESP;
            end
            RESP: begin
                if (bus.mem_rvalid_i) begin
                    w_state_nxt = IDLE;
                    w_owner_nxt = NONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_owner_nxt = NONE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_owner <= NONE;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Transaction fields are captured once in IDLE and held through REQ/RESP.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_strb     <= '0;
            r_wdata    <= '0;
            r_lane     <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
        end else if (w_latch) begin
            if (w_sel == D) begin
                r_we       <= bus.d_we_i;
                r_addr     <= bus.d_addr_i;
                r_strb     <= bus.d_we_i ? bus.d_strb_i : '0;
                r_wdata    <= bus.d_wdata_i;
                r_lane     <= bus.d_byte_lane_i;
                r_size     <= bus.d_size_i;
                r_unsigned <= bus.d_unsigned_i;
            end else begin
                r_we       <= 1'b0;
                r_addr     <= bus.if_addr_i;
                r_strb     <= '0;
                r_wdata    <= '0;
                r_lane     <= '0;
                r_size     <= 2'(WORD);
                r_unsigned <= 1'b0;
            end
        end
    end

    load_align u_load_align (
        .i_rdata    (bus.mem_rdata_i),
        .i_lane     (r_lane),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_load)
    );

    // Bus fields are only driven while requesting so idle outputs stay zero.
    assign bus.mem_req_o   = w_in_req;
    assign bus.mem_we_o    = w_in_req & r_we;
    assign bus.mem_addr_o  = w_in_req ? r_addr  : '0;
    assign bus.mem_strb_o  = w_in_req ? r_strb  : '0;
    assign bus.mem_wdata_o = w_in_req ? r_wdata : '0;

    // Responses pass straight through from mem_rvalid_i in RESP.
    assign w_if_hit = w_resp & (r_owner == IF);
    assign w_d_hit  = w_resp & (r_owner == D);

    assign bus.if_rvalid_o = w_if_hit;
    assign bus.if_rdata_o  = w_if_hit ? bus.mem_rdata_i : '0;
    assign bus.d_done_o    = w_d_hit;
    assign bus.d_rdata_o   = (w_d_hit & ~r_we) ? w_load : '0;
    assign bus.d_stall_o   = w_d_req & ~w_d_hit;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized fetch/load/store traffic against a transaction-level model.
module tb_mem_port_arbiter;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   cyc    = 0;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    // Model state: owner codes 1 = fetch, 2 = data.
    int          last_own = 1;
    int          e_own;
    logic        e_we;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [1:0]  e_lane;
    logic [1:0]  e_size;
    logic        e_uns;
    int          done_cyc;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int pick(input bit ifp, input bit dp, input int last);
        if (ifp && dp) begin
`ifdef PEARL_ARB_RR_EN
            return (last == 2) ? 1 : 2;
`else
            return (last >= 0) ? 2 : 2;
`endif
        end
        if (dp)  return 2;
        if (ifp) return 1;
        return 0;
    endfunction

    // Load result from the byte-count / offset description of the access.
    function automatic logic [31:0] ref_load(input logic [31:0] rd, input int lane,
                                             input int size, input bit uns);
        longint nb, off, span, v, raw;
        nb   = (size == 0) ? 1 : (size == 1) ? 2 : 4;
        off  = (size == 0) ? lane : (size == 1) ? (lane / 2) * 2 : 0;
        span = longint'(1) << (8 * nb);
        raw  = {32'd0, rd};
        v    = (raw >> (8 * off)) % span;
        if (!uns && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    task automatic issue_expect();
        e_own = pick(bus.if_req_i, bus.d_we_i | bus.d_re_i, last_own);
        if (e_own == 2) begin
            e_we    = bus.d_we_i;
            e_addr  = bus.d_addr_i;
            e_strb  = bus.d_we_i ? bus.d_strb_i : 4'h0;
            e_wdata = bus.d_wdata_i;
            e_lane  = bus.d_byte_lane_i;
            e_size  = bus.d_size_i;
            e_uns   = bus.d_unsigned_i;
        end else begin
            e_we    = 1'b0;
            e_addr  = bus.if_addr_i;
            e_strb  = 4'h0;
            e_wdata = 32'h0;
            e_lane  = 2'd0;
            e_size  = 2'd2;
            e_uns   = 1'b0;
        end
    endtask

    // Runs one transaction starting from the IDLE cycle in which it is requested.
    task automatic serve(input int gw, input int rw, input logic [31:0] rd);
        logic [31:0] exp_rd;
        logic        dp;
        exp_rd = (e_own == 2) ? (e_we ? 32'h0 : ref_load(rd, int'(e_lane), int'(e_size), e_uns)) : rd;
        for (int k = 0; k <= gw; k++) begin
            @(negedge clk_i);
            bus.mem_gnt_i    = (k == gw);
            bus.mem_rvalid_i = 1'($urandom_range(0, 1));
            bus.mem_rdata_i  = $urandom;
            if (e_own == 2) begin
                bus.d_addr_i      = $urandom;
                bus.d_wdata_i     = $urandom;
                bus.d_strb_i      = 4'($urandom_range(0, 15));
                bus.d_byte_lane_i = 2'($urandom_range(0, 3));
                bus.d_size_i      = 2'($urandom_range(0, 3));
                bus.d_unsigned_i  = 1'($urandom_range(0, 1));
            end else begin
                bus.if_addr_i = $urandom;
            end
            #1;
            dp = bus.d_we_i | bus.d_re_i;
            check_eq("req_mem_req", 32'(bus.mem_req_o), 32'd1);
            check_eq("req_mem_we", 32'(bus.mem_we_o), 32'(e_we));
            check_eq("req_mem_addr", bus.mem_addr_o, e_addr);
            check_eq("req_mem_strb", 32'(bus.mem_strb_o), 32'(e_strb));
            if (e_we) check_eq("req_mem_wdata", bus.mem_wdata_o, e_wdata);
            check_eq("req_no_pulse", 32'({bus.d_done_o, bus.if_rvalid_o}), 32'd0);
            check_eq("req_stall", 32'(bus.d_stall_o), 32'(dp));
        end
        for (int j = 0; j <= rw; j++) begin
            @(negedge clk_i);
            bus.mem_gnt_i    = 1'b0;
            bus.mem_rvalid_i = (j == rw);
            bus.mem_rdata_i  = (j == rw) ? rd : $urandom;
            #1;
            dp = bus.d_we_i | bus.d_re_i;
            check_eq("resp_mem_req", 32'(bus.mem_req_o), 32'd0);
            check_eq("resp_if_rvalid", 32'(bus.if_rvalid_o), 32'((j == rw) && (e_own == 1)));
            check_eq("resp_d_done", 32'(bus.d_done_o), 32'((j == rw) && (e_own == 2)));
            check_eq("resp_stall", 32'(bus.d_stall_o), 32'(dp && !((j == rw) && (e_own == 2))));
            if (j == rw) begin
                done_cyc = cyc;
                if (e_own == 1) check_eq("if_rdata", bus.if_rdata_o, rd);
                else            check_eq("d_rdata", bus.d_rdata_o, exp_rd);
            end
        end
        last_own = e_own;
        @(negedge clk_i);
        bus.mem_rvalid_i = 1'b0;
        if (e_own == 2) begin
            bus.d_we_i = 1'b0;
            bus.d_re_i = 1'b0;
        end else begin
            bus.if_req_i = 1'b0;
        end
        #1;
        check_eq("idle_no_pulse", 32'({bus.d_done_o, bus.if_rvalid_o}), 32'd0);
        check_eq("idle_stall", 32'(bus.d_stall_o), 32'(bus.d_we_i | bus.d_re_i));
    endtask

    task automatic rand_d_req();
        bus.d_addr_i = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 1) == 1) begin
            bus.d_we_i    = 1'b1;
            bus.d_re_i    = 1'b0;
            bus.d_strb_i  = 4'($urandom_range(1, 15));
            bus.d_wdata_i = $urandom;
        end else begin
            bus.d_we_i        = 1'b0;
            bus.d_re_i        = 1'b1;
            bus.d_byte_lane_i = 2'($urandom_range(0, 3));
            bus.d_size_i      = 2'($urandom_range(0, 3));
            bus.d_unsigned_i  = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        bus.if_req_i = 0; bus.if_addr_i = 0;
        bus.d_we_i = 0; bus.d_re_i = 0; bus.d_addr_i = 0; bus.d_strb_i = 0;
        bus.d_wdata_i = 0; bus.d_byte_lane_i = 0; bus.d_size_i = 0; bus.d_unsigned_i = 0;
        bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;

        // Reset state.
        repeat (2) @(negedge clk_i);
        #1;
        check_eq("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
        check_eq("rst_mem_we", 32'(bus.mem_we_o), 32'd0);
        check_eq("rst_mem_addr", bus.mem_addr_o, 32'd0);
        check_eq("rst_mem_strb", 32'(bus.mem_strb_o), 32'd0);
        check_eq("rst_mem_wdata", bus.mem_wdata_o, 32'd0);
        check_eq("rst_if_rvalid", 32'(bus.if_rvalid_o), 32'd0);
        check_eq("rst_if_rdata", bus.if_rdata_o, 32'd0);
        check_eq("rst_d_done", 32'(bus.d_done_o), 32'd0);
        check_eq("rst_d_rdata", bus.d_rdata_o, 32'd0);
        check_eq("rst_d_stall", 32'(bus.d_stall_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1;

        // Signed byte load from lane 3.
        bus.d_re_i = 1; bus.d_addr_i = 32'h100; bus.d_byte_lane_i = 2'd3;
        bus.d_size_i = 2'd0; bus.d_unsigned_i = 0;
        #1;
        check_eq("lb_stall_c0", 32'(bus.d_stall_o), 32'd1);
        s0 = cyc;
        issue_expect();
        check_eq("lb_model_value", ref_load(32'h80FF_0011, 3, 0, 1'b0), 32'hFFFF_FF80);
        serve(0, 0, 32'h80FF_0011);
        check_eq("lb_latency", 32'(done_cyc - s0), 32'd2);

        // Store with three wait states before the grant.
        bus.d_we_i = 1; bus.d_addr_i = 32'h204; bus.d_strb_i = 4'b1100;
        bus.d_wdata_i = 32'hBEEF_0000;
        issue_expect();
        serve(3, 0, $urandom);

        // Simultaneous fetch and unsigned half load.
        bus.if_req_i = 1; bus.if_addr_i = 32'h0;
        bus.d_re_i = 1; bus.d_addr_i = 32'h300; bus.d_byte_lane_i = 2'd2;
        bus.d_size_i = 2'd1; bus.d_unsigned_i = 1;
        issue_expect();
`ifdef PEARL_ARB_RR_EN
        check_eq("tie_winner", 32'(e_own), 32'd1);
`else
        check_eq("tie_winner", 32'(e_own), 32'd2);
`endif
        serve(0, 0, 32'h8001_1234);
        issue_expect();
        serve(0, 0, 32'h8001_1234);

        // Back-to-back zero-wait fetches.
        bus.if_req_i = 1;
        s0 = cyc;
        for (int i = 0; i < 3; i++) begin
            bus.if_req_i  = 1;
            bus.if_addr_i = 32'(4 * i);
            issue_expect();
            serve(0, 0, $urandom);
            check_eq("fetch_b2b_cycle", 32'(done_cyc - s0), 32'(2 + 3 * i));
        end

        // Reset while in RESP, then a stray response.
        bus.d_re_i = 1; bus.d_addr_i = 32'h400; bus.d_size_i = 2'd2;
        @(negedge clk_i);
        bus.mem_gnt_i = 1;
        #1;
        check_eq("rstmid_req", 32'(bus.mem_req_o), 32'd1);
        @(negedge clk_i);
        bus.mem_gnt_i = 0;
        #1;
        check_eq("rstmid_resp_req", 32'(bus.mem_req_o), 32'd0);
        rst_ni = 0; bus.d_re_i = 0;
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hDEAD_BEEF;
        #1;
        check_eq("rstmid_mem_req", 32'(bus.mem_req_o), 32'd0);
        check_eq("rstmid_pulses", 32'({bus.d_done_o, bus.if_rvalid_o}), 32'd0);
        check_eq("rstmid_d_rdata", bus.d_rdata_o, 32'd0);
        check_eq("rstmid_if_rdata", bus.if_rdata_o, 32'd0);
        check_eq("rstmid_stall", 32'(bus.d_stall_o), 32'd0);
        last_own = 1;
        @(negedge clk_i);
        rst_ni = 1;
        #1;
        check_eq("stray_rvalid_0", 32'({bus.d_done_o, bus.if_rvalid_o, bus.mem_req_o}), 32'd0);
        @(negedge clk_i);
        #1;
        check_eq("stray_rvalid_1", 32'({bus.d_done_o, bus.if_rvalid_o, bus.mem_req_o}), 32'd0);
        bus.mem_rvalid_i = 0;

        // Randomized mixed traffic.
        for (int it = 0; it < 60; it++) begin
            if (!bus.if_req_i && $urandom_range(0, 1) == 1) begin
                bus.if_req_i  = 1;
                bus.if_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            if (!(bus.d_we_i | bus.d_re_i) && $urandom_range(0, 1) == 1) rand_d_req();
            if (!bus.if_req_i && !(bus.d_we_i | bus.d_re_i)) begin
                bus.if_req_i  = 1;
                bus.if_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            issue_expect();
            serve(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
        end

        // Idle response with no owner.
        bus.if_req_i = 0; bus.d_we_i = 0; bus.d_re_i = 0;
        @(negedge clk_i);
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = $urandom;
        #1;
        check_eq("idle_rvalid", 32'({bus.d_done_o, bus.if_rvalid_o, bus.mem_req_o}), 32'd0);
        @(negedge clk_i);
        #1;
        check_eq("idle_rvalid_2", 32'({bus.d_done_o, bus.if_rvalid_o, bus.mem_req_o}), 32'd0);
        bus.mem_rvalid_i = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
